// File: rtl/mapa_writer.sv
// mapa_writer: write-side controller for the 40x30 game map memory.
// Game logic sends cell updates through a valid/ready port. The updates are
// buffered in a small FIFO and written to the map only while the VGA side is
// not reading. After reset, or on clear_req, the controller sweeps the whole
// map to its initial contents.
// Optional build macro: MAPA_BORDA_EN. When it is defined, the sweep writes
// obstacles (0001) on the border cells and empty (0000) everywhere else.
// When it is undefined, every cell is cleared to 0000.
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
// cmd_ready comes only from registered FIFO occupancy and is low while reset
// is high. The producer must hold cmd_x/cmd_y/cmd_data stable while cmd_valid
// is high and cmd_ready is low. An out-of-range command still completes its
// handshake, but it is discarded and drop pulses one cycle later.
//
// busy is the FSM state made visible: 1 in CLEAR, 0 in RUN.
// When clear_req is seen on an edge, that edge issues no write. The sweep
// pointer returns to (0,0), and any queued commands stay in the FIFO.
module mapa_writer #(
  parameter int MAPA_WIDTH  = 40,
  parameter int MAPA_HEIGHT = 30,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_req,
  input  logic       vga_read,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_x,
  input  logic [9:0] cmd_y,
  input  logic [3:0] cmd_data,
  output logic       wr_en,
  output logic [9:0] wr_x,
  output logic [9:0] wr_y,
  output logic [3:0] wr_data,
  output logic       busy,
  output logic       clear_done,
  output logic       drop
);

  localparam int         AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [9:0] X_LIM    = 10'(MAPA_WIDTH);
  localparam logic [9:0] Y_LIM    = 10'(MAPA_HEIGHT);
  localparam logic [9:0] X_LAST   = 10'(MAPA_WIDTH - 1);
  localparam logic [9:0] Y_LAST   = 10'(MAPA_HEIGHT - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [9:0]    sx_q, sy_q, sx_d, sy_d;

  // FIFO entry layout: {x[9:0], y[9:0], data[3:0]}
  logic [23:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q, rd_ptr_d, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [23:0]   head;

  logic          full, empty;
  logic          accept, in_range, push, pop;
  logic          sweep_fire, last_cell;
  logic [3:0]    sweep_data;

  logic          wr_en_d, clear_done_d, drop_d;
  logic [9:0]    wr_x_d, wr_y_d;
  logic [3:0]    wr_data_d;

  // Handshake and FIFO status decode
  always_comb begin
    full      = (count_q == FULL_CNT);
    empty     = (count_q == '0);
    cmd_ready = !full && !reset;
    accept    = cmd_valid && cmd_ready;
    in_range  = (cmd_x < X_LIM) && (cmd_y < Y_LIM);
    push      = accept && in_range;
    head      = fifo_mem[rd_ptr_q];
    busy      = (state_q == ST_CLEAR);
  end

  // Initial cell contents written by the sweep at the current pointer
  always_comb begin
`ifdef MAPA_BORDA_EN
    if (sx_q == '0 || sx_q == X_LAST || sy_q == '0 || sy_q == Y_LAST)
      sweep_data = 4'b0001;
    else
      sweep_data = 4'b0000;
`else
    sweep_data = 4'b0000;
`endif
  end

  // Next state, sweep pointer, FIFO pointers and write-port values
  always_comb begin
    state_d      = state_q;
    sx_d         = sx_q;
    sy_d         = sy_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    wr_en_d      = 1'b0;
    wr_x_d       = wr_x;
    wr_y_d       = wr_y;
    wr_data_d    = wr_data;
    clear_done_d = 1'b0;
    drop_d       = accept && !in_range;

    last_cell  = (sx_q == X_LAST) && (sy_q == Y_LAST);
    sweep_fire = (state_q == ST_CLEAR) && !vga_read && !clear_req;
    pop        = (state_q == ST_RUN) && !empty && !vga_read && !clear_req;

    if (clear_req) begin
      // A new sweep starts from the origin; queued commands wait for it to finish
      state_d = ST_CLEAR;
      sx_d    = '0;
      sy_d    = '0;
    end else if (sweep_fire) begin
      wr_en_d   = 1'b1;
      wr_x_d    = sx_q;
      wr_y_d    = sy_q;
      wr_data_d = sweep_data;
      if (last_cell) begin
        clear_done_d = 1'b1;
        state_d      = ST_RUN;
        sx_d         = '0;
        sy_d         = '0;
      end else if (sx_q == X_LAST) begin
        sx_d = '0;
        sy_d = sy_q + 10'd1;
      end else begin
        sx_d = sx_q + 10'd1;
      end
    end else if (pop) begin
      wr_en_d   = 1'b1;
      wr_x_d    = head[23:14];
      wr_y_d    = head[13:4];
      wr_data_d = head[3:0];
    end

    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  // State, pointers, occupancy and registered write port
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      sx_q       <= '0;
      sy_q       <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wr_en      <= 1'b0;
      wr_x       <= '0;
      wr_y       <= '0;
      wr_data    <= '0;
      clear_done <= 1'b0;
      drop       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      wr_en      <= wr_en_d;
      wr_x       <= wr_x_d;
      wr_y       <= wr_y_d;
      wr_data    <= wr_data_d;
      clear_done <= clear_done_d;
      drop       <= drop_d;
    end
  end

  // Command storage; only the occupancy and pointers need a reset
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {cmd_x, cmd_y, cmd_data};
  end

endmodule

// File: tb/tb_mapa_writer.sv
// Testbench for mapa_writer. Directed stimulus drives the design. A queue-based
// model predicts every output cycle by cycle, and directed literal checks
// anchor the model.
module tb_mapa_writer;

  localparam int W  = 40;
  localparam int H  = 30;
  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear_req = 1'b0;
  logic       vga_read = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [9:0] cmd_x = '0;
  logic [9:0] cmd_y = '0;
  logic [3:0] cmd_data = '0;
  logic       wr_en;
  logic [9:0] wr_x;
  logic [9:0] wr_y;
  logic [3:0] wr_data;
  logic       busy;
  logic       clear_done;
  logic       drop;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int drop_cnt = 0;
  int cd_cnt = 0;

  mapa_writer #(.MAPA_WIDTH(W), .MAPA_HEIGHT(H), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .vga_read(vga_read),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .cmd_data(cmd_data), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data), .busy(busy), .clear_done(clear_done), .drop(drop)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] sweep_val(input int x, input int y);
`ifdef MAPA_BORDA_EN
    return (x == 0 || x == W-1 || y == 0 || y == H-1) ? 4'b0001 : 4'b0000;
`else
    return 4'b0000;
`endif
  endfunction

  // ---------------- model + compare (negedge) ----------------
  logic [23:0] exp_q[$];
  bit          m_clear = 1'b1;
  int          m_k = 0;
  logic        e_wr_en = 1'b0, e_clear_done = 1'b0, e_drop = 1'b0;
  logic [9:0]  e_wr_x = '0, e_wr_y = '0;
  logic [3:0]  e_wr_data = '0;

  initial begin
    logic [23:0] ent;
    bit          e_ready;
    @(posedge clk);
    forever begin
      @(negedge clk);
      // outputs produced by the edge just passed
      check("wr_en", wr_en, e_wr_en);
      check("wr_x", wr_x, e_wr_x);
      check("wr_y", wr_y, e_wr_y);
      check("wr_data", wr_data, e_wr_data);
      check("clear_done", clear_done, e_clear_done);
      check("drop", drop, e_drop);
      check("busy", busy, m_clear);
      e_ready = !reset && (exp_q.size() < FD);
      check("cmd_ready", cmd_ready, e_ready);
      // predict the next edge from the inputs now held stable
      e_wr_en = 1'b0; e_clear_done = 1'b0; e_drop = 1'b0;
      if (reset) begin
        m_clear = 1'b1; m_k = 0; exp_q.delete();
        e_wr_x = '0; e_wr_y = '0; e_wr_data = '0;
      end else begin
        if (clear_req) begin
          m_clear = 1'b1; m_k = 0;
        end else if (m_clear) begin
          if (!vga_read) begin
            e_wr_en = 1'b1;
            e_wr_x = 10'(m_k % W); e_wr_y = 10'(m_k / W);
            e_wr_data = sweep_val(m_k % W, m_k / W);
            if (m_k == W*H - 1) begin
              e_clear_done = 1'b1; m_clear = 1'b0; m_k = 0;
            end else m_k++;
          end
        end else if (!vga_read && exp_q.size() > 0) begin
          ent = exp_q.pop_front();
          e_wr_en = 1'b1;
          e_wr_x = ent[23:14]; e_wr_y = ent[13:4]; e_wr_data = ent[3:0];
        end
        if (cmd_valid && e_ready) begin
          if (cmd_x < W && cmd_y < H) exp_q.push_back({cmd_x, cmd_y, cmd_data});
          else e_drop = 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if (wr_en) wr_cnt++;
    if (drop) drop_cnt++;
    if (clear_done) cd_cnt++;
  endtask

  task automatic send(input int x, input int y, input int d);
    int budget = 0;
    cmd_valid = 1'b1; cmd_x = 10'(x); cmd_y = 10'(y); cmd_data = 4'(d);
    while (!cmd_ready && budget < 200) begin step(); budget++; end
    if (!cmd_ready) check("send_timeout", budget, 0);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_req = 1'b1; step(); clear_req = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin step(); cyc++; end while (!clear_done && cyc < 5000);
    if (!clear_done) check("done_timeout", cyc, 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int cyc, base, dbase, cbase;
    bit done;

    // T1: reset values, then unstalled sweep
    repeat (3) step();
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 1);
    check("rst_ready", cmd_ready, 0);
    check("rst_wr_x", wr_x, 0);
    reset = 1'b0;
    #1 check("ready_after_reset", cmd_ready, 1);
    base = wr_cnt; cyc = 0; done = 0;
    while (!done && cyc < 3000) begin
      step(); cyc++;
      if (wr_en && wr_y == 10'd5 && wr_x == 10'd0)
`ifdef MAPA_BORDA_EN
        check("sweep_0_5", wr_data, 4'b0001);
`else
        check("sweep_0_5", wr_data, 4'b0000);
`endif
      if (wr_en && wr_y == 10'd5 && wr_x == 10'd5) check("sweep_5_5", wr_data, 4'b0000);
      if (clear_done) begin
        done = 1;
        check("done_x", wr_x, 39);
        check("done_y", wr_y, 29);
        check("done_wr_en", wr_en, 1);
      end
    end
    check("sweep_cycles", cyc, 1200);
    check("sweep_writes", wr_cnt - base, 1200);
    step();
    check("run_busy", busy, 0);

    // T2: sweep with vga_read toggling every cycle
    pulse_clear();
    cyc = 0; vga_read = 1'b1;
    do begin step(); cyc++; vga_read = ~vga_read; end while (!clear_done && cyc < 5000);
    vga_read = 1'b0;
    check("stall_sweep_cycles", cyc, 2400);
    repeat (2) step();

    // T3: back-to-back commands, latency and throughput
    send(10, 10, 4'b0010);
    check("lat_idle", wr_en, 0);
    send(11, 10, 4'b1100);
    check("c1_en", wr_en, 1);
    check("c1_x", wr_x, 10);
    check("c1_y", wr_y, 10);
    check("c1_d", wr_data, 4'b0010);
    step();
    check("c2_en", wr_en, 1);
    check("c2_x", wr_x, 11);
    check("c2_d", wr_data, 4'b1100);
    step();
    check("c2_after", wr_en, 0);

    // T4: FIFO fill with vga_read held, then release
    vga_read = 1'b1;
    for (int i = 0; i < 4; i++) send(i, 20, i + 1);
    check("ready_full", cmd_ready, 0);
    cmd_valid = 1'b1; cmd_x = 10'd4; cmd_y = 10'd20; cmd_data = 4'd5;
    repeat (2) step();
    check("full_no_write", wr_en, 0);
    check("full_ready_hold", cmd_ready, 0);
    base = wr_cnt;
    vga_read = 1'b0;
    send(4, 20, 5);
    repeat (6) step();
    check("drain_writes", wr_cnt - base, 5);

    // T5: out-of-range commands
    base = wr_cnt; dbase = drop_cnt;
    send(40, 0, 4'b0001);
    send(0, 30, 4'b0010);
    repeat (3) step();
    check("drop_count", drop_cnt - dbase, 2);
    check("drop_no_write", wr_cnt - base, 0);

    // T6: clear_req at sweep cell 600 with 2 commands queued
    pulse_clear();
    base = wr_cnt;
    send(7, 7, 4'b0010);
    send(8, 8, 4'b0001);
    while (wr_cnt - base < 600) step();
    cbase = cd_cnt;
    pulse_clear();
    base = wr_cnt;
    wait_done(cyc);
    check("restart_writes", wr_cnt - base, 1200);
    check("restart_done_once", cd_cnt - cbase, 1);
    repeat (3) step();
    check("queued_after_sweep", wr_cnt - base, 1202);

    // T7: clear_req on the edge of the last sweep cell
    pulse_clear();
    base = wr_cnt; cbase = cd_cnt;
    while (wr_cnt - base < 1199) step();
    pulse_clear();
    check("last_abort_no_done", cd_cnt - cbase, 0);
    check("last_abort_busy", busy, 1);
    base = wr_cnt;
    wait_done(cyc);
    check("last_abort_writes", wr_cnt - base, 1200);
    check("last_abort_done_once", cd_cnt - cbase, 1);
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
